inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fifo.sv | 57 +++++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: bus width, reset vector, FSM states
// and the {pc, word} payload carried through the decode buffer.
package inst_fetch_pkg;

    localparam int DATA_BUS = 32;
    localparam logic [DATA_BUS-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        WAIT_WORD  = 2'd1,
        WAIT_READY = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_BUS-1:0] pc;
        logic [DATA_BUS-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Two-entry in-order decode buffer with flush; the head is
// presented combinationally.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_data,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t mem [DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push    = push && !flush;
    assign do_pop     = pop && !flush && (count != 2'd0);
    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push)
                wr_ptr <= ~wr_ptr;
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: pc register, cache request FSM and the
// two-entry buffer feeding decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = inst_fetch_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] cache_addr,
    output logic        cache_enable,
    input  logic        cache_ready,
    input  logic [31:0] cache_data,
    input  logic        cache_data_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    import inst_fetch_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic         discard;
    logic         boot;
    logic [1:0]   count;
    logic [1:0]   after_pop;
    logic         pop;
    logic         hit;
    logic         word_ok;
    logic         push;
    logic [31:0]  redirect_aligned;
    fetch_entry_t push_data;
    fetch_entry_t head;

    assign cache_addr       = {pc[31:2], 2'b00};
    assign redirect_aligned = redirect_pc & ~32'h3;

    // A slot is free if one exists now or the head leaves this cycle.
    assign pop          = inst_valid && inst_ready;
    assign after_pop    = count - {1'b0, pop};
    assign cache_enable = rst_n && (state == FETCH) && cache_ready
                       && !redirect_valid
                       && (after_pop < 2'(FIFO_DEPTH));

    assign hit     = cache_enable && cache_data_valid;
    assign word_ok = (state == WAIT_WORD) && cache_data_valid
                  && !discard && !redirect_valid;
    assign push    = hit || word_ok;

    assign push_data.pc   = pc;
    assign push_data.word = cache_data;

    assign inst    = head.word;
    assign inst_pc = head.pc;

    inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .head_valid(inst_valid),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            state   <= FETCH;
            discard <= 1'b0;
            boot    <= 1'b1;
        end else begin
            boot <= 1'b0;
            if (redirect_valid) begin
                pc <= redirect_aligned;
                if (state == WAIT_WORD) begin
                    if (cache_data_valid) begin
                        state   <= WAIT_READY;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
            end else begin
                unique case (state)
                    FETCH: begin
                        if (hit) begin
                            pc <= pc + 32'd4;
                        end else if (cache_enable) begin
                            state   <= WAIT_WORD;
                            discard <= 1'b0;
                        end else if (boot && !cache_ready) begin
                            // a request abandoned by reset may still answer
                            state <= WAIT_READY;
                        end
                    end
                    WAIT_WORD: begin
                        if (cache_data_valid) begin
                            if (!discard)
                                pc <= pc + 32'd4;
                            state   <= WAIT_READY;
                            discard <= 1'b0;
                        end
                    end
                    WAIT_READY: begin
                        if (cache_ready)
                            state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios followed by
// random cache/redirect/decode traffic against a queue-based model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cache_addr;
    logic        cache_enable;
    logic        cache_ready = 1'b0;
    logic [31:0] cache_data = '0;
    logic        cache_data_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cache_addr      (cache_addr),
        .cache_enable    (cache_enable),
        .cache_ready     (cache_ready),
        .cache_data      (cache_data),
        .cache_data_valid(cache_data_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    // reference model: expected buffer contents plus request bookkeeping
    logic [31:0] m_pc = 32'h0;
    logic [63:0] mq[$];
    bit          pending, drop, need_ready, boot;
    bit          do_flush, do_push;
    logic [63:0] push_val;
    bit          mpop, en;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_enable", {63'd0, cache_enable}, 64'd0);
            check("rst_addr", {32'd0, cache_addr}, 64'd0);
            m_pc = 32'h0;
            mq.delete();
            pending = 0; drop = 0; need_ready = 0; boot = 1;
            do_flush = 1; do_push = 0;
        end else begin
            mpop = (mq.size() != 0) && inst_ready;
            en = !pending && !need_ready && cache_ready && !redirect_valid
                 && ((mq.size() - (mpop ? 1 : 0)) < 2);
            check("cache_enable", {63'd0, cache_enable}, {63'd0, en});
            check("cache_addr", {32'd0, cache_addr}, {32'd0, m_pc[31:2], 2'b00});
            do_flush = 0; do_push = 0;
            if (redirect_valid) begin
                mq.delete();
                do_flush = 1;
                m_pc = {redirect_pc[31:2], 2'b00};
                if (pending) begin
                    if (cache_data_valid) begin
                        pending = 0; need_ready = 1;
                    end else begin
                        drop = 1;
                    end
                end
            end else begin
                if (mpop) void'(mq.pop_front());
                if (en && cache_data_valid) begin
                    push_val = {m_pc, cache_data};
                    mq.push_back(push_val); do_push = 1;
                    m_pc = m_pc + 32'd4;
                end else if (en) begin
                    pending = 1; drop = 0;
                end else if (pending) begin
                    if (cache_data_valid) begin
                        if (!drop) begin
                            push_val = {m_pc, cache_data};
                            mq.push_back(push_val); do_push = 1;
                            m_pc = m_pc + 32'd4;
                        end
                        pending = 0; need_ready = 1;
                    end
                end else if (need_ready) begin
                    if (cache_ready) need_ready = 0;
                end else if (boot && !cache_ready) begin
                    need_ready = 1;
                end
            end
            boot = 0;
        end
    end

    always @(posedge clk) begin
        if (do_flush) exp_q.delete();
        if (do_push) exp_q.push_back(push_val);
        do_flush = 0;
        do_push = 0;
    end

    // monitor: every accepted head must match the oldest expected entry
    always @(negedge clk) begin
        check("inst_valid", {63'd0, inst_valid}, {63'd0, exp_q.size() != 0});
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
            end else begin
                check("inst_payload", {inst_pc, inst}, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic rdy, input logic dv, input logic rv,
                         input logic [31:0] rpc, input logic ird, input int n);
        for (int i = 0; i < n; i++) begin
            cache_ready = rdy;
            cache_data_valid = dv;
            cache_data = $urandom;
            redirect_valid = rv;
            redirect_pc = rpc;
            inst_ready = ird;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // streaming hits out of reset
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 0, 0, 1, 1);
            check("stream_addr", {32'd0, cache_addr}, 64'(4 * i));
        end
        drive(1, 1, 0, 0, 1, 3);
        // miss at 0x20
        drive(1, 0, 1, 32'h20, 1, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 2);
        drive(1, 0, 0, 0, 1, 1);
        check("miss_next_addr", {32'd0, cache_addr}, 64'h24);
        drive(1, 1, 0, 0, 1, 2);
        // decode stalled with a hit cache
        drive(1, 0, 1, 32'h0, 1, 1);
        drive(1, 1, 0, 0, 0, 5);
        check("stall_no_req", {63'd0, cache_enable}, 64'd0);
        drive(1, 1, 0, 0, 1, 3);
        // redirect on the miss word cycle
        drive(1, 0, 1, 32'h40, 1, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(0, 1, 1, 32'h103, 1, 1);
        check("drop_empty", {63'd0, inst_valid}, 64'd0);
        check("drop_addr", {32'd0, cache_addr}, 64'h100);
        drive(0, 0, 0, 0, 1, 1);
        drive(1, 1, 0, 0, 1, 3);
        // redirect with a full buffer
        drive(1, 1, 0, 0, 0, 3);
        drive(1, 1, 1, 32'h200, 1, 1);
        check("flush_valid", {63'd0, inst_valid}, 64'd0);
        drive(1, 1, 0, 0, 1, 1);
        check("flush_head_pc", {32'd0, inst_pc}, 64'h200);
        // wrap from the top of the address space
        drive(1, 0, 1, 32'hFFFF_FFFC, 1, 1);
        drive(1, 1, 0, 0, 1, 1);
        check("wrap_addr", {32'd0, cache_addr}, 64'h0);
        // reset in the middle of a miss
        drive(1, 0, 1, 32'h80, 1, 1);
        drive(1, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        rst_n = 1'b0;
        exp_q.delete();
        drive(0, 1, 0, 0, 1, 2);
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 1, 3);
        check("rst_word_ignored", {63'd0, inst_valid}, 64'd0);
        drive(1, 1, 0, 0, 1, 3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 19) == 0, $urandom,
                  $urandom_range(0, 9) < 7, 1);
        end
        drive(1, 0, 0, 0, 1, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
